memcpy_ctrl: RTL and testbench

Word-granular block-copy sequencer that owns the data-memory port on behalf of the memcpy extension of the RV32I core. On a `start` pulse it copies `word_cnt` 32-bit words from `src_addr` to `dst_addr` through the single dmem read/write port. While it runs, it arbitrates that port against CPU load/store traffic and stalls the CPU when the CPU loses arbitration. It sits between the core's memory-address/write-data muxes and `dmem`.

---
 rtl/memcpy_ctrl.sv | 89 ++++++++
 tb/tb_memcpy_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/memcpy_ctrl.sv
// memcpy_ctrl: word-granular block-copy sequencer that owns the dmem port and stalls the CPU on conflicts.
// Optional fair arbitration (one-cycle CPU yield in RD) is enabled by defining MEMCPY_FAIR_ARB_EN.
module memcpy_ctrl #(
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [31:0]   src_addr_i,
  input  logic [31:0]   dst_addr_i,
  input  logic [LW-1:0] word_cnt_i,
  input  logic          cpu_req_i,
  input  logic [31:0]   mem_rdata_i,
  output logic          mem_sel_o,
  output logic [31:0]   mem_addr_o,
  output logic          mem_we_o,
  output logic [31:0]   mem_wdata_o,
  output logic          cpu_stall_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [LW-1:0] remaining_o
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t        state_q, state_d;
  logic [29:0]   src_q, src_d, dst_q, dst_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [31:0]   buf_q, buf_d;
  logic          yield;
  logic          unused_addr_lsb;
  assign unused_addr_lsb = ^{src_addr_i[1:0], dst_addr_i[1:0]};
`ifdef MEMCPY_FAIR_ARB_EN
  logic yld_q;
  // Yield at most once in a row so the copy always makes forward progress.
  assign yield = (state_q == RD) && cpu_req_i && !yld_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) yld_q <= 1'b0;
    else        yld_q <= yield;
`else
  assign yield = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = (word_cnt_i != '0) ? RD : DONE;
        src_d   = src_addr_i[31:2];
        dst_d   = dst_addr_i[31:2];
        cnt_d   = word_cnt_i;
      end
      RD: if (!yield) begin
        buf_d   = mem_rdata_i;
        state_d = WR;
      end
      WR: begin
        src_d   = src_q + 30'd1;
        dst_d   = dst_q + 30'd1;
        cnt_d   = cnt_q - LW'(1);
        state_d = (cnt_q == LW'(1)) ? DONE : RD;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy_o      = (state_q == RD) || (state_q == WR);
  assign done_o      = (state_q == DONE);
  assign mem_sel_o   = busy_o && !yield;
  assign mem_we_o    = (state_q == WR);
  assign mem_addr_o  = (state_q == RD) ? {src_q, 2'b00} : (state_q == WR) ? {dst_q, 2'b00} : 32'h0;
  assign mem_wdata_o = mem_we_o ? buf_q : 32'h0;
  assign cpu_stall_o = cpu_req_i && mem_sel_o;
  assign remaining_o = busy_o ? cnt_q : '0;
endmodule

// File: tb/tb_memcpy_ctrl.sv
// tb_memcpy_ctrl: scoreboard bench for memcpy_ctrl with a behavioural 256-word dmem.
module tb_memcpy_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, cpu_req = 1'b0;
  logic [31:0] src = '0, dst = '0;
  logic [15:0] wc = '0;
  logic [31:0] mem_rdata, mem_addr, mem_wdata;
  logic        mem_sel, mem_we, cpu_stall, busy, done;
  logic [15:0] remaining;
  typedef struct packed {logic [29:0] a; logic [31:0] d;} wr_t;
  wr_t         sb[$];
  wr_t         mon_e;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] mem [256];
  int          busy_c, done_c, done_at, stall_c, we_c;
  logic [15:0] rem_q[$];
  logic [31:0] raddr_q[$];
  logic [15:0] exp_rem [8] = '{16'd4, 16'd4, 16'd3, 16'd3, 16'd2, 16'd2, 16'd1, 16'd1};
  memcpy_ctrl #(.LW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .src_addr_i(src), .dst_addr_i(dst),
    .word_cnt_i(wc), .cpu_req_i(cpu_req), .mem_rdata_i(mem_rdata), .mem_sel_o(mem_sel),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .cpu_stall_o(cpu_stall), .busy_o(busy), .done_o(done), .remaining_o(remaining));
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_sel && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  function automatic logic [31:0] init_val(input logic [29:0] w);
    return 32'hA000_0000 | {24'h0, w[7:0]};
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (mem_sel && mem_we) begin
      if (sb.size() == 0) check("unexpected write", mem_addr, 32'hFFFF_FFFF);
      else begin
        mon_e = sb.pop_front();
        check("wr addr", mem_addr, {mon_e.a, 2'b00});
        check("wr data", mem_wdata, mon_e.d);
      end
    end
  task automatic expect_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    logic [29:0] sp, dp;
    wr_t e;
    sp = s[31:2];
    dp = d[31:2];
    for (int i = 0; i < n; i++) begin
      e.a = dp;
      e.d = init_val(sp);
      sb.push_back(e);
      sp = sp + 30'd1;
      dp = dp + 30'd1;
    end
  endtask
  task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                     input bit cpu, input bit repulse, input int k_max);
    expect_copy(s, d, int'(n));
    busy_c = 0; done_c = 0; done_at = 0; stall_c = 0; we_c = 0;
    rem_q.delete();
    raddr_q.delete();
    @(negedge clk);
    src = s; dst = d; wc = n; start = 1'b1; cpu_req = cpu;
    for (int k = 1; k <= k_max; k++) begin
      @(negedge clk);
      start = repulse && (k == 2);
      if (busy) begin busy_c++; rem_q.push_back(remaining); end
      if (done) begin done_c++; done_at = k; end
      if (cpu_stall) stall_c++;
      if (mem_we) we_c++;
      if (mem_sel && !mem_we) raddr_q.push_back(mem_addr);
    end
    cpu_req = 1'b0;
    check("scoreboard drained", 32'(sb.size()), 32'd0);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + 32'(i);
    repeat (2) @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst mem_sel", {31'd0, mem_sel}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst remaining", {16'd0, remaining}, 32'd0);
    rst_n = 1'b1;
    // basic 4-word copy
    run(32'h100, 32'h200, 16'd4, 1'b0, 1'b0, 12);
    check("t1 busy cycles", 32'(busy_c), 32'd8);
    check("t1 done count", 32'(done_c), 32'd1);
    check("t1 done cycle", 32'(done_at), 32'd9);
    check("t1 stall", 32'(stall_c), 32'd0);
    check("t1 rem len", 32'(rem_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < rem_q.size(); i++) check("t1 remaining", {16'd0, rem_q[i]}, {16'd0, exp_rem[i]});
    for (int i = 0; i < 4; i++) check("t1 mem", mem[128 + i], 32'hA000_0040 + 32'(i));
    // zero-length request
    run(32'h0, 32'h280, 16'd0, 1'b0, 1'b0, 4);
    check("t2 done cycle", 32'(done_at), 32'd1);
    check("t2 done count", 32'(done_c), 32'd1);
    check("t2 busy", 32'(busy_c), 32'd0);
    check("t2 we", 32'(we_c), 32'd0);
    // CPU contention across a 2-word copy
    run(32'h110, 32'h2C0, 16'd2, 1'b1, 1'b0, 10);
    check("t3 stall", 32'(stall_c), 32'd4);
`ifdef MEMCPY_FAIR_ARB_EN
    check("t3 busy", 32'(busy_c), 32'd6);
    check("t3 done cycle", 32'(done_at), 32'd7);
`else
    check("t3 busy", 32'(busy_c), 32'd4);
    check("t3 done cycle", 32'(done_at), 32'd5);
`endif
    check("t3 mem0", mem[176], 32'hA000_0044);
    check("t3 mem1", mem[177], 32'hA000_0045);
    // address wrap and ignored low bits
    run(32'hFFFF_FFFC, 32'h40, 16'd2, 1'b0, 1'b0, 6);
    check("t4 rd0", raddr_q.size() > 0 ? raddr_q[0] : 32'hDEAD, 32'hFFFF_FFFC);
    check("t4 rd1", raddr_q.size() > 1 ? raddr_q[1] : 32'hDEAD, 32'h0);
    run(32'h103, 32'h50, 16'd1, 1'b0, 1'b0, 4);
    check("t5 rd0", raddr_q.size() > 0 ? raddr_q[0] : 32'hDEAD, 32'h100);
    check("t5 mem", mem[20], 32'hA000_0040);
    // asynchronous reset during WR of word 2
    expect_copy(32'h120, 32'h300, 1);
    @(negedge clk);
    src = 32'h120; dst = 32'h300; wc = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6 busy", {31'd0, busy}, 32'd0);
    check("t6 mem_we", {31'd0, mem_we}, 32'd0);
    check("t6 mem_sel", {31'd0, mem_sel}, 32'd0);
    check("t6 mem_addr", mem_addr, 32'd0);
    check("t6 remaining", {16'd0, remaining}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("t6 sb", 32'(sb.size()), 32'd0);
    check("t6 mem0", mem[192], 32'hA000_0048);
    for (int i = 1; i < 4; i++) check("t6 untouched", mem[192 + i], 32'hA000_00C0 + 32'(i));
    run(32'h130, 32'h380, 16'd2, 1'b0, 1'b0, 8);
    check("t7 done count", 32'(done_c), 32'd1);
    check("t7 mem", mem[225], 32'hA000_004D);
    // start re-pulsed while busy
    run(32'h140, 32'h3C0, 16'd2, 1'b0, 1'b1, 14);
    check("t8 done count", 32'(done_c), 32'd1);
    check("t8 busy", 32'(busy_c), 32'd4);
    check("t8 we", 32'(we_c), 32'd2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
